// File: rtl/result_fifo.sv
// result_fifo: buffers wrapper results for a slower consumer, with level and sticky error flags
module result_fifo #(
  parameter int DATA_W    = 21,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_LVL = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_ok, rd_ok;
  assign full        = count_q == (ADDR_W+1)'(DEPTH);
  assign empty       = count_q == '0;
  assign almost_full = count_q >= (ADDR_W+1)'(AFULL_LVL);
  assign count       = count_q;
  assign dout        = dout_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  // accept decisions on pre-edge state; a read frees a slot so a full FIFO still takes a write
  always_comb begin
    wr_ok   = wr & (~full | rd);
    rd_ok   = rd & ~empty;
    wptr_d  = wr_ok ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d  = rd_ok ? rptr_q + ADDR_W'(1) : rptr_q;
    count_d = (wr_ok & ~rd_ok) ? count_q + (ADDR_W+1)'(1) :
              (rd_ok & ~wr_ok) ? count_q - (ADDR_W+1)'(1) : count_q;
    dout_d  = rd_ok ? mem[rptr_q] : dout_q;
    ovf_d   = ovf_q | (wr & full & ~rd);
    udf_d   = udf_q | (rd & empty);
  end
  // storage array is not reset; writes are blocked during reset
  always_ff @(posedge clk)
    if (!rst && wr_ok) mem[wptr_q] <= din;
  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: scoreboard bench for result_fifo
module tb_result_fifo;
  logic        clk = 1'b0;
  logic        rst, wr, rd;
  logic [20:0] din, dout;
  logic        full, empty, almost_full, overflow, underflow;
  logic [3:0]  count;
  int          total = 0, bad = 0;
  logic [20:0] sb [$];
  logic [20:0] exp_dout;
  logic        exp_ovf, exp_udf;

  result_fifo dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(full), 32'(sb.size() == 8));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= 6));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_udf));
  endtask

  task automatic step(input logic w, input logic [20:0] d, input logic r);
    bit f, e;
    f = sb.size() == 8;
    e = sb.size() == 0;
    rst = 1'b0; wr = w; din = d; rd = r;
    if (r && !e) exp_dout = sb.pop_front();
    if (w && (!f || r)) sb.push_back(d);
    if (w && f && !r) exp_ovf = 1'b1;
    if (r && e) exp_udf = 1'b1;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1'b1; wr = w; rd = r; din = 21'($urandom);
    @(posedge clk); #1;
    sb.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 21'(i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 21'(32'h100 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 21'(32'h1ABCD + i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 21'(32'h200 + i), 1'b0);
    step(1'b1, 21'h1FFFF, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 21'h00042, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 21'(32'h300 + i), 1'b0);
    step(1'b1, 21'h00077, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 21'(32'h400 + i), i == 3);
    for (int i = 0; i < 3; i++) step(1'b1, 21'(32'h500 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b1, 21'h00011, 1'b0);
    step(1'b1, 21'h00012, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
